// File: rtl/comparison_operand_loader.sv
// Nibble-serial loader that stages X, Y and the operation select, then commits them
// atomically to the comparator. Optional edge-qualified load via COMP_LOAD_EDGE_EN.
module comparison_operand_loader #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         data_in,
    input  logic               load,
    input  logic               clear,
    output logic [7:0]         z,
    output logic [1:0]         select,
    output logic               valid,
    output logic               done,
    output logic [1:0]         stage,
    output logic [COUNT_W-1:0] commit_count
);

    typedef enum logic [1:0] {
        S_X   = 2'd0,
        S_Y   = 2'd1,
        S_SEL = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] x_r;
    logic [3:0] y_r;
    logic       acc_s;

`ifdef COMP_LOAD_EDGE_EN
    logic       load_q_r;

    // Previous load level; resets high so a strobe held through reset is not taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q_r <= 1'b1;
        end else begin
            load_q_r <= load;
        end
    end

    // Accept only the rising edge of the strobe.
    always_comb begin
        acc_s = load & ~load_q_r;
    end
`else
    // Every high cycle of the strobe is an accepted load.
    always_comb begin
        acc_s = load;
    end
`endif

    assign stage = state_r;

    // Sequencer, staging registers and committed outputs; clear beats an accepted load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_X;
            x_r          <= 4'h0;
            y_r          <= 4'h0;
            z            <= 8'h00;
            select       <= 2'b00;
            valid        <= 1'b0;
            done         <= 1'b0;
            commit_count <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_r <= S_X;
                x_r     <= 4'h0;
                y_r     <= 4'h0;
            end else begin
                case (state_r)
                    S_X: begin
                        if (acc_s) begin
                            x_r     <= data_in;
                            state_r <= S_Y;
                        end else begin
                            state_r <= S_X;
                        end
                    end
                    S_Y: begin
                        if (acc_s) begin
                            y_r     <= data_in;
                            state_r <= S_SEL;
                        end else begin
                            state_r <= S_Y;
                        end
                    end
                    S_SEL: begin
                        if (acc_s) begin
                            z            <= {y_r, x_r};
                            select       <= data_in[1:0];
                            valid        <= 1'b1;
                            done         <= 1'b1;
                            commit_count <= commit_count + COUNT_W'(1);
                            state_r      <= S_X;
                        end else begin
                            state_r <= S_SEL;
                        end
                    end
                    default: begin
                        state_r <= S_X;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comparison_operand_loader.sv
// Self-checking bench for comparison_operand_loader: directed scenarios plus random
// stimulus against a queue-based model of the nibble collection rules.
module tb_comparison_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data_in = 4'h0;
    logic       load = 1'b0;
    logic       clear = 1'b0;

    logic [7:0] z;
    logic [1:0] select;
    logic       valid;
    logic       done;
    logic [1:0] stage;
    logic [7:0] commit_count;

    logic [7:0] z2;
    logic [1:0] select2;
    logic       valid2;
    logic       done2;
    logic [1:0] stage2;
    logic [1:0] commit_count2;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [3:0] q[$];
    logic [7:0] m_z;
    logic [1:0] m_sel;
    logic       m_valid;
    logic       m_done;
    int         m_cnt;
    logic       m_prev;

    always #5 clk = ~clk;

    comparison_operand_loader #(.COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clear(clear),
        .z(z), .select(select), .valid(valid), .done(done), .stage(stage),
        .commit_count(commit_count)
    );

    comparison_operand_loader #(.COUNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .clear(clear),
        .z(z2), .select(select2), .valid(valid2), .done(done2), .stage(stage2),
        .commit_count(commit_count2)
    );

    task automatic apply(input logic [3:0] d, input logic l, input logic c, input logic r);
        logic acc;
        data_in = d;
        load    = l;
        clear   = c;
        rst     = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_z = 8'h00; m_sel = 2'b00; m_valid = 1'b0; m_done = 1'b0;
            m_cnt = 0; m_prev = 1'b1;
        end else begin
`ifdef COMP_LOAD_EDGE_EN
            acc = l && !m_prev;
`else
            acc = l;
`endif
            m_prev = l;
            m_done = 1'b0;
            if (c) begin
                q.delete();
            end else if (acc) begin
                if (q.size() == 2) begin
                    m_z     = {q[1], q[0]};
                    m_sel   = d[1:0];
                    m_valid = 1'b1;
                    m_done  = 1'b1;
                    m_cnt   = m_cnt + 1;
                    q.delete();
                end else begin
                    q.push_back(d);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_stage;
        apply(4'h6, 1'b1, 1'b0, 1'b1);
        apply(4'h6, 1'b1, 1'b0, 1'b1);
        total++;
        if ({z, select, valid, done, stage, commit_count} !== 22'h0) begin
            $display("FAIL reset_outputs: got z=%h sel=%b v=%b d=%b st=%0d cnt=%0d want all 0",
                     z, select, valid, done, stage, commit_count);
        end else passed++;
        total++;
        if ({valid2, stage2, commit_count2} !== 5'h0) begin
            $display("FAIL reset_small: got v=%b st=%0d cnt=%0d want 0", valid2, stage2, commit_count2);
        end else passed++;
        apply(4'h6, 1'b1, 1'b0, 1'b0);
`ifdef COMP_LOAD_EDGE_EN
        exp_stage = 2'd0;
`else
        exp_stage = 2'd1;
`endif
        total++;
        if (stage !== exp_stage) begin
            $display("FAIL reset_release_load: got stage=%0d want %0d", stage, exp_stage);
        end else passed++;
        apply(4'h0, 1'b0, 1'b1, 1'b0);
        total++;
        if (stage !== 2'd0 || valid !== 1'b0) begin
            $display("FAIL reset_then_clear: got stage=%0d valid=%b want 0 0", stage, valid);
        end else passed++;
    endtask

    task automatic test_nominal();
        apply(4'h5, 1'b1, 1'b0, 1'b0);
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h9, 1'b1, 1'b0, 1'b0);
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h2, 1'b1, 1'b0, 1'b0);
        total++;
        if (z !== 8'h95 || select !== 2'b10 || valid !== 1'b1 || done !== 1'b1 ||
            commit_count !== 8'd1 || stage !== 2'd0) begin
            $display("FAIL nominal_commit: got z=%h sel=%b v=%b d=%b cnt=%0d st=%0d want 95 10 1 1 1 0",
                     z, select, valid, done, commit_count, stage);
        end else passed++;
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (done !== 1'b0 || z !== 8'h95) begin
            $display("FAIL nominal_done_pulse: got done=%b z=%h want 0 95", done, z);
        end else passed++;
    endtask

    task automatic test_atomicity();
        apply(4'h3, 1'b1, 1'b0, 1'b0);
        total++;
        if (stage !== 2'd1 || z !== 8'h95) begin
            $display("FAIL atomic_x: got stage=%0d z=%h want 1 95", stage, z);
        end else passed++;
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h7, 1'b1, 1'b0, 1'b0);
        total++;
        if (stage !== 2'd2 || z !== 8'h95 || select !== 2'b10) begin
            $display("FAIL atomic_y: got stage=%0d z=%h sel=%b want 2 95 10", stage, z, select);
        end else passed++;
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h1, 1'b1, 1'b0, 1'b0);
        total++;
        if (z !== 8'h73 || select !== 2'b01 || commit_count !== 8'd2 || done !== 1'b1) begin
            $display("FAIL atomic_commit: got z=%h sel=%b cnt=%0d done=%b want 73 01 2 1",
                     z, select, commit_count, done);
        end else passed++;
    endtask

    task automatic test_clear();
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'hA, 1'b1, 1'b0, 1'b0);
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'hB, 1'b1, 1'b1, 1'b0);
        total++;
        if (stage !== 2'd0 || z !== 8'h73 || commit_count !== 8'd2 || valid !== 1'b1) begin
            $display("FAIL clear_priority: got stage=%0d z=%h cnt=%0d v=%b want 0 73 2 1",
                     stage, z, commit_count, valid);
        end else passed++;
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h1, 1'b1, 1'b0, 1'b0);
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'h2, 1'b1, 1'b0, 1'b0);
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        apply(4'hF, 1'b1, 1'b0, 1'b0);
        total++;
        if (z !== 8'h21 || select !== 2'b11 || commit_count !== 8'd3) begin
            $display("FAIL clear_fresh_set: got z=%h sel=%b cnt=%0d want 21 11 3", z, select, commit_count);
        end else passed++;
    endtask

    task automatic test_held_load();
        int c0;
        int exp_delta;
        logic [7:0] exp_z;
        apply(4'h0, 1'b0, 1'b0, 1'b0);
        c0 = m_cnt;
        for (int i = 0; i < 10; i++) begin
            apply(4'h4, 1'b1, 1'b0, 1'b0);
            total++;
            if (stage !== 2'(q.size()) || commit_count !== 8'(m_cnt)) begin
                $display("FAIL held_load_cycle%0d: got stage=%0d cnt=%0d want %0d %0d",
                         i, stage, commit_count, q.size(), m_cnt);
            end else passed++;
        end
`ifdef COMP_LOAD_EDGE_EN
        exp_delta = 0;
        exp_z = 8'h21;
`else
        exp_delta = 3;
        exp_z = 8'h44;
`endif
        total++;
        if (stage !== 2'd1 || commit_count !== 8'(c0 + exp_delta) || z !== exp_z) begin
            $display("FAIL held_load_final: got stage=%0d cnt=%0d z=%h want 1 %0d %h",
                     stage, commit_count, z, c0 + exp_delta, exp_z);
        end else passed++;
    endtask

    task automatic test_wrap();
        int c0;
        apply(4'h0, 1'b0, 1'b1, 1'b0);
        c0 = m_cnt;
        for (int k = 1; k <= 4; k++) begin
            apply(4'(k), 1'b1, 1'b0, 1'b0);
            apply(4'h0, 1'b0, 1'b0, 1'b0);
            apply(4'(k + 8), 1'b1, 1'b0, 1'b0);
            apply(4'h0, 1'b0, 1'b0, 1'b0);
            apply(4'(k), 1'b1, 1'b0, 1'b0);
            total++;
            if (commit_count2 !== 2'(c0 + k) || valid2 !== 1'b1 || z2 !== {4'(k + 8), 4'(k)}) begin
                $display("FAIL wrap_seq%0d: got cnt=%0d v=%b z=%h want %0d 1 %h",
                         k, commit_count2, valid2, z2, 2'(c0 + k), {4'(k + 8), 4'(k)});
            end else passed++;
            apply(4'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [21:0] got;
        logic [21:0] want;
        for (int i = 0; i < 400; i++) begin
            apply(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 59) == 0));
            got  = {z, select, valid, done, stage, commit_count};
            want = {m_z, m_sel, m_valid, m_done, 2'(q.size()), 8'(m_cnt)};
            total++;
            if (got !== want || commit_count2 !== 2'(m_cnt) || valid2 !== m_valid) begin
                $display("FAIL random_cycle%0d: got %h small_cnt=%0d want %h small_cnt=%0d",
                         i, got, commit_count2, want, 2'(m_cnt));
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_atomicity();
        test_clear();
        test_held_load();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
